// File: rtl/sram_write_arbiter_pkg.sv
// Shared SRAM request/result types and the write-arbiter state encoding.
// Pure types and constants; no logic, so no latency or backpressure behaviour.
package sram_write_arbiter_pkg;

  localparam int SRAM_ADDRESS_WIDTH = 20;
  localparam int SRAM_DATA_WIDTH    = 16;

  typedef struct packed {
    logic [SRAM_ADDRESS_WIDTH-1:0] address;
    logic                          we_n;
    logic                          oe_n;
    logic                          den;
    logic [SRAM_DATA_WIDTH-1:0]    dout;
  } SramRequest_t;

  typedef struct packed {
    logic                       done;
    logic [SRAM_DATA_WIDTH-1:0] din;
  } SramResult_t;

  typedef enum logic {
    ARB_IDLE,
    ARB_ISSUE
  } SramWriteArbState_t;

  localparam SramRequest_t SRAM_REQ_IDLE = '{
    address: '0,
    we_n:    1'b1,
    oe_n:    1'b1,
    den:     1'b0,
    dout:    '0
  };

endpackage

// File: rtl/sram_write_arbiter_if.sv
// Requester-side valid/ready write ports plus the controller request/result pair.
// Wires only; the master side is the environment, the slave side is the arbiter.
interface sram_write_arbiter_if #(
  parameter int NUM_PORTS = 3
);
  import sram_write_arbiter_pkg::*;

  logic [NUM_PORTS-1:0]                         wrValid;
  logic [NUM_PORTS-1:0][SRAM_ADDRESS_WIDTH-1:0] wrAddress;
  logic [NUM_PORTS-1:0][SRAM_DATA_WIDTH-1:0]    wrData;
  logic [NUM_PORTS-1:0]                         wrReady;
  logic [NUM_PORTS-1:0]                         wrAck;
  logic                                         hold;
  SramRequest_t                                 sramRequest;
  SramResult_t                                  sramResult;
  logic                                         busy;

  modport master (
    output wrValid, wrAddress, wrData, hold, sramResult,
    input  wrReady, wrAck, sramRequest, busy
  );

  modport slave (
    input  wrValid, wrAddress, wrData, hold, sramResult,
    output wrReady, wrAck, sramRequest, busy
  );

endinterface

// File: rtl/sram_write_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first requester strictly after last_grant wins.
// Zero latency; no backpressure, the caller decides whether the grant is used.
module rr_priority_picker #(
  parameter int NUM_PORTS     = 3,
  parameter int PORT_ID_WIDTH = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0]     req,
  input  logic [PORT_ID_WIDTH-1:0] last_grant,
  output logic                     any_valid,
  output logic [PORT_ID_WIDTH-1:0] winner,
  output logic [NUM_PORTS-1:0]     grant
);

  always_comb begin
    int idx;
    any_valid = 1'b0;
    winner    = '0;
    idx       = 0;
    // Scan farthest-first so the nearest requester after last_grant overwrites.
    for (int k = NUM_PORTS; k >= 1; k--) begin
      idx = (int'(last_grant) + k) % NUM_PORTS;
      if (req[idx]) begin
        any_valid = 1'b1;
        winner    = PORT_ID_WIDTH'(idx);
      end
    end
    grant = any_valid ? (NUM_PORTS'(1) << winner) : '0;
  end

endmodule

// File: rtl/sram_write_arbiter.sv
// Round-robin share of the controller's renderer write slot; one held write at a time.
// Accept is combinational; request shows next cycle; wrAck one cycle after done; hold blocks accepts only.
module sram_write_arbiter
  import sram_write_arbiter_pkg::*;
#(
  parameter int NUM_PORTS     = 3,
  parameter int PORT_ID_WIDTH = $clog2(NUM_PORTS)
) (
  input  logic                  clk,
  input  logic                  rst,
  sram_write_arbiter_if.slave   bus
);

  SramWriteArbState_t            state_q, state_d;
  logic [PORT_ID_WIDTH-1:0]      last_grant_q, last_grant_d;
  logic [SRAM_ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [SRAM_DATA_WIDTH-1:0]    data_q, data_d;
  logic [PORT_ID_WIDTH-1:0]      id_q, id_d;
  logic [NUM_PORTS-1:0]          ack_q, ack_d;

  logic                          pick_any;
  logic [PORT_ID_WIDTH-1:0]      pick_winner;
  logic [NUM_PORTS-1:0]          pick_grant;
  logic                          commit;
  logic                          accept;
  logic                          result_unused;

  rr_priority_picker #(
    .NUM_PORTS     (NUM_PORTS),
    .PORT_ID_WIDTH (PORT_ID_WIDTH)
  ) u_picker (
    .req        (bus.wrValid),
    .last_grant (last_grant_q),
    .any_valid  (pick_any),
    .winner     (pick_winner),
    .grant      (pick_grant)
  );

  assign commit = (state_q == ARB_ISSUE) && bus.sramResult.done;
  // A freed slot can be refilled in the same cycle it commits.
  assign accept = !rst && !bus.hold && pick_any && ((state_q == ARB_IDLE) || commit);
  assign result_unused = ^bus.sramResult.din;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    data_d       = data_q;
    id_d         = id_q;
    ack_d        = '0;
    if (commit) begin
      ack_d   = NUM_PORTS'(1) << id_q;
      state_d = ARB_IDLE;
    end
    if (accept) begin
      state_d      = ARB_ISSUE;
      last_grant_d = pick_winner;
      addr_d       = bus.wrAddress[pick_winner];
      data_d       = bus.wrData[pick_winner];
      id_d         = pick_winner;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= PORT_ID_WIDTH'(NUM_PORTS - 1);
      addr_q       <= '0;
      data_q       <= '0;
      id_q         <= '0;
      ack_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      id_q         <= id_d;
      ack_q        <= ack_d;
    end
  end

  always_comb begin
    bus.sramRequest = SRAM_REQ_IDLE;
    if (state_q == ARB_ISSUE) begin
      bus.sramRequest.address = addr_q;
      bus.sramRequest.we_n    = 1'b0;
      bus.sramRequest.oe_n    = 1'b1;
      bus.sramRequest.den     = 1'b1;
      bus.sramRequest.dout    = data_q;
    end
  end

  assign bus.wrReady = accept ? pick_grant : '0;
  assign bus.wrAck   = ack_q;
  assign bus.busy    = (state_q == ARB_ISSUE);

endmodule

// File: tb/tb_sram_write_arbiter.sv
// Randomised and directed stimulus for sram_write_arbiter against a transaction-level model.
module tb_sram_write_arbiter;
  import sram_write_arbiter_pkg::*;

  localparam int N  = 3;
  localparam int AW = SRAM_ADDRESS_WIDTH;
  localparam int DW = SRAM_DATA_WIDTH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #20 clk = ~clk;

  sram_write_arbiter_if #(.NUM_PORTS(N)) bus ();

  sram_write_arbiter #(.NUM_PORTS(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // requester-side state
  bit          pend  [N];
  logic [AW-1:0] paddr [N];
  logic [DW-1:0] pdata [N];
  int          req_prob  = 0;
  int          done_mode = 0;   // 0 alternate, 1 manual, 2 alternate plus random extras
  bit          phase     = 1'b0;
  bit          st_done   = 1'b0;
  bit          st_hold   = 1'b0;
  bit          st_rst    = 1'b0;

  // transaction-level model of the slot
  bit            m_busy;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  int            m_id;
  int            m_last;
  int            m_ackp;

  logic [N-1:0]  obs_ready, obs_ack;
  logic          obs_busy;
  SramRequest_t  obs_req;
  int            acc_q[$];
  int            cyc = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", tag, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_addr = '0;
    m_data = '0;
    m_id   = 0;
    m_last = N - 1;
    m_ackp = -1;
  endtask

  task automatic cycle();
    logic [N-1:0] exp_ready;
    logic [N-1:0] exp_ack;
    SramRequest_t exp_req;
    int w;
    bit commit;
    bit can_acc;
    for (int i = 0; i < N; i++) begin
      if (!pend[i] && $urandom_range(0, 99) < req_prob) begin
        pend[i]  = 1'b1;
        paddr[i] = AW'($urandom);
        pdata[i] = DW'($urandom);
      end
    end
    if (done_mode == 0) st_done = phase;
    else if (done_mode == 2) st_done = phase | ($urandom_range(0, 3) == 0);
    for (int i = 0; i < N; i++) begin
      bus.wrValid[i]   = pend[i];
      bus.wrAddress[i] = paddr[i];
      bus.wrData[i]    = pdata[i];
    end
    bus.hold            = st_hold;
    bus.sramResult.done = st_done;
    bus.sramResult.din  = DW'($urandom);
    rst                 = st_rst;
    #2;
    w = -1;
    for (int k = 1; k <= N; k++) begin
      if (w < 0 && pend[(m_last + k) % N]) w = (m_last + k) % N;
    end
    commit  = m_busy && st_done;
    can_acc = !st_rst && !st_hold && (w >= 0) && (!m_busy || commit);
    exp_ready = can_acc ? (N'(1) << w) : '0;
    exp_ack   = (m_ackp >= 0) ? (N'(1) << m_ackp) : '0;
    if (m_busy) exp_req = '{address: m_addr, we_n: 1'b0, oe_n: 1'b1, den: 1'b1, dout: m_data};
    else        exp_req = SRAM_REQ_IDLE;
    obs_ready = bus.wrReady;
    obs_ack   = bus.wrAck;
    obs_busy  = bus.busy;
    obs_req   = bus.sramRequest;
    check("ready", obs_ready, exp_ready);
    check("ack",   obs_ack,   exp_ack);
    check("busy",  obs_busy,  m_busy);
    check("req",   obs_req,   exp_req);
    for (int i = 0; i < N; i++) begin
      if (obs_ready[i]) begin
        acc_q.push_back(i);
        pend[i] = 1'b0;
      end
    end
    if (st_rst) begin
      model_reset();
    end else begin
      m_ackp = commit ? m_id : -1;
      if (can_acc) begin
        m_busy = 1'b1;
        m_addr = paddr[w];
        m_data = pdata[w];
        m_id   = w;
        m_last = w;
      end else if (commit) begin
        m_busy = 1'b0;
      end
    end
    phase = ~phase;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    st_rst = 1'b1;
    cycle();
    cycle();
    st_rst = 1'b0;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
  endtask

  task automatic drain();
    clear_reqs();
    req_prob  = 0;
    done_mode = 0;
    st_hold   = 1'b0;
    for (int t = 0; t < 8 && m_busy; t++) cycle();
    check("drain_idle", bus.busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d actual=running expected=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int ack_cnt;
    bit seen;
    logic [AW-1:0] stall_addr;
    clear_reqs();
    for (int i = 0; i < N; i++) begin
      paddr[i] = '0;
      pdata[i] = '0;
    end
    bus.wrValid = '0; bus.wrAddress = '0; bus.wrData = '0;
    bus.hold = 1'b0; bus.sramResult = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    st_rst = 1'b0;

    // reset state with nothing pending
    cycle();
    check("rst_ready", obs_ready, 3'b000);
    check("rst_busy",  obs_busy,  1'b0);
    check("rst_req",   obs_req,   SRAM_REQ_IDLE);

    // single write from port 1
    pend[1] = 1'b1; paddr[1] = 20'h00123; pdata[1] = 16'h5A5A;
    cycle();
    check("sw_ready", obs_ready, 3'b010);
    cycle();
    check("sw_we_n", obs_req.we_n, 1'b0);
    check("sw_den",  obs_req.den,  1'b1);
    check("sw_addr", obs_req.address, 20'h00123);
    check("sw_dout", obs_req.dout, 16'h5A5A);
    check("sw_one_ready", obs_ready, 3'b000);
    seen = 1'b0;
    for (int t = 0; t < 6 && !seen; t++) begin
      cycle();
      seen = (obs_ack != '0);
    end
    check("sw_ack", obs_ack, 3'b010);
    cycle();
    check("sw_idle", obs_busy, 1'b0);

    // fairness under continuous requests
    do_reset();
    req_prob = 100;
    acc_q.delete();
    ack_cnt = 0;
    for (int t = 0; t < 16; t++) begin
      cycle();
      if (t >= 4 && obs_ack != '0) ack_cnt++;
    end
    check("fair_len", acc_q.size() >= 6, 1'b1);
    for (int i = 0; i < 6; i++) check("fair_order", acc_q[i], i % 3);
    check("fair_rate", ack_cnt, 6);
    drain();

    // stall: done low for 10 cycles while a write is held
    done_mode = 1;
    st_done = 1'b0;
    pend[0] = 1'b1; paddr[0] = AW'($urandom); pdata[0] = DW'($urandom);
    stall_addr = paddr[0];
    cycle();
    check("stall_accept", obs_ready, 3'b001);
    pend[1] = 1'b1; paddr[1] = AW'($urandom); pdata[1] = DW'($urandom);
    for (int t = 0; t < 10; t++) begin
      cycle();
      check("stall_ready", obs_ready, 3'b000);
      check("stall_busy",  obs_busy,  1'b1);
      check("stall_addr",  obs_req.address, stall_addr);
    end
    st_done = 1'b1;
    cycle();
    check("stall_b2b", obs_ready, 3'b010);
    st_done = 1'b0;
    cycle();
    check("stall_ack", obs_ack, 3'b001);
    drain();

    // hold while port 2 is in flight and port 0 waits
    done_mode = 1;
    st_done = 1'b0;
    pend[2] = 1'b1; paddr[2] = AW'($urandom); pdata[2] = DW'($urandom);
    cycle();
    check("hold_acc2", obs_ready, 3'b100);
    pend[0] = 1'b1; paddr[0] = AW'($urandom); pdata[0] = DW'($urandom);
    st_hold = 1'b1;
    cycle();
    st_done = 1'b1;
    cycle();
    check("hold_block", obs_ready, 3'b000);
    st_done = 1'b0;
    cycle();
    check("hold_ack2", obs_ack, 3'b100);
    check("hold_wait", obs_ready, 3'b000);
    st_hold = 1'b0;
    cycle();
    check("hold_release", obs_ready, 3'b001);
    drain();

    // reset while a write is held
    done_mode = 1;
    st_done = 1'b0;
    pend[1] = 1'b1; paddr[1] = AW'($urandom); pdata[1] = DW'($urandom);
    cycle();
    check("rmw_accept", obs_ready, 3'b010);
    cycle();
    st_rst = 1'b1;
    cycle();
    st_rst = 1'b0;
    for (int i = 0; i < N; i++) pend[i] = 1'b1;
    cycle();
    check("rmw_no_ack", obs_ack, 3'b000);
    check("rmw_idle",   obs_req, SRAM_REQ_IDLE);
    check("rmw_first",  obs_ready, 3'b001);
    st_done = 1'b1;
    cycle();
    check("rmw_no_ack2", obs_ack, 3'b000);
    drain();

    // request arriving in IDLE on a done cycle
    done_mode = 1;
    pend[0] = 1'b1; paddr[0] = AW'($urandom); pdata[0] = DW'($urandom);
    st_done = 1'b1;
    cycle();
    check("ph_accept", obs_ready, 3'b001);
    st_done = 1'b0;
    cycle();
    check("ph_busy", obs_busy, 1'b1);
    check("ph_no_ack", obs_ack, 3'b000);
    st_done = 1'b1;
    cycle();
    check("ph_no_ack2", obs_ack, 3'b000);
    st_done = 1'b0;
    cycle();
    check("ph_ack", obs_ack, 3'b001);
    drain();

    // randomised traffic, holds and occasional resets
    done_mode = 2;
    for (int t = 0; t < 600; t++) begin
      req_prob = (t < 300) ? 40 : 90;
      st_hold  = ($urandom_range(0, 7) == 0);
      st_rst   = ($urandom_range(0, 199) == 0);
      cycle();
    end
    st_rst  = 1'b0;
    st_hold = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
